// File: rtl/mod_m_tick_counter.sv
// Free-running modulo-M counter with a terminal-count tick.
// Counts 0..M-1 and wraps to 0; o_max_tick is high while the count equals M-1
// and serves as a periodic one-cycle enable for downstream timing logic.
// Optional build macro: MOD_M_TICK_COUNTER_PARAM_CHECK_EN enables an
// elaboration-time range check on M and a simulation check on the count.
module mod_m_tick_counter #(
   parameter int N = 4,
   parameter int M = 10
) (
   input  logic         i_clk,
   input  logic         i_reset,
   output logic         o_max_tick,
   output logic [N-1:0] o_q
);

   // Terminal value; M-1 always fits in N bits for the legal range.
   localparam logic [N-1:0] MaxVal = N'(M - 1);

   logic [N-1:0] r_count;
   logic [N-1:0] w_count_next;
   logic         w_at_max;

   // Wrap is an explicit compare, not natural overflow, so any M works.
   always_comb begin
      w_at_max     = (r_count == MaxVal);
      w_count_next = r_count + 1'b1;
      if (w_at_max) begin
         w_count_next = '0;
      end
   end

   // Count register; synchronous reset wins over the wrap.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_next;
      end
   end

   assign o_q        = r_count;
   assign o_max_tick = w_at_max;

`ifdef MOD_M_TICK_COUNTER_PARAM_CHECK_EN
   // Reject out-of-range moduli at elaboration.
   if ((M < 2) || (longint'(M) > (longint'(1) << N))) begin : g_bad_modulus
      $fatal(1, "mod_m_tick_counter: illegal M=%0d for N=%0d", M, N);
   end

   // The count must never escape the 0..M-1 range once reset has been applied.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         assert (longint'(r_count) < longint'(M))
            else $error("mod_m_tick_counter: count %0d out of range (M=%0d)", r_count, M);
      end
   end
`endif

endmodule

// File: tb/tb_mod_m_tick_counter.sv
// Self-checking bench for mod_m_tick_counter.
// Two instances (N=4/M=10 and N=3/M=8) are compared each cycle against a
// reference that counts edges since the last reset and takes that modulo M.
module tb_mod_m_tick_counter;

   localparam int NA = 4;
   localparam int MA = 10;
   localparam int NB = 3;
   localparam int MB = 8;

   logic          clk;
   logic          reset_a;
   logic          reset_b;
   logic          tick_a;
   logic          tick_b;
   logic [NA-1:0] q_a;
   logic [NB-1:0] q_b;

   int n_checks;
   int n_errors;
   int k_a;  // edges since reset release, instance A
   int k_b;  // edges since reset release, instance B

   mod_m_tick_counter #(.N(NA), .M(MA)) u_dut_a (
      .i_clk      (clk),
      .i_reset    (reset_a),
      .o_max_tick (tick_a),
      .o_q        (q_a)
   );

   mod_m_tick_counter #(.N(NB), .M(MB)) u_dut_b (
      .i_clk      (clk),
      .i_reset    (reset_b),
      .o_max_tick (tick_b),
      .o_q        (q_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Apply reset values for one edge, advance the model, compare both instances.
   task automatic step(input logic rst_a, input logic rst_b);
      reset_a = rst_a;
      reset_b = rst_b;
      @(posedge clk);
      #1;
      k_a = rst_a ? 0 : k_a + 1;
      k_b = rst_b ? 0 : k_b + 1;
      check("q_a", int'(q_a), k_a % MA);
      check("tick_a", int'(tick_a), int'((k_a % MA) == MA - 1));
      check("q_b", int'(q_b), k_b % MB);
      check("tick_b", int'(tick_b), int'((k_b % MB) == MB - 1));
   endtask

   initial begin
      int n_ticks;
      int last_tick;
      int guard;

      n_checks = 0;
      n_errors = 0;
      k_a      = 0;
      k_b      = 0;
      reset_a  = 1'b1;
      reset_b  = 1'b1;
      #1;

      // Reset state.
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      check("reset_q_a", int'(q_a), 0);
      check("reset_tick_a", int'(tick_a), 0);

      // Count to max and wrap: 13 edges on A, 16 covers two full periods on B.
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b0);
         if (i == 8)  check("max_q_a", int'(q_a), 9);
         if (i == 8)  check("max_tick_a", int'(tick_a), 1);
         if (i == 9)  check("wrap_q_a", int'(q_a), 0);
         if (i == 9)  check("wrap_tick_a", int'(tick_a), 0);
         if (i == 6)  check("max_tick_b", int'(tick_b), 1);
      end

      // Periodicity: 50 clocks give exactly 5 single-cycle ticks, 10 apart.
      n_ticks   = 0;
      last_tick = -1;
      for (int i = 0; i < 50; i++) begin
         step(1'b0, 1'b0);
         if (tick_a) begin
            if (last_tick >= 0) check("tick_spacing_a", i - last_tick, MA);
            last_tick = i;
            n_ticks++;
         end
      end
      check("tick_count_a", n_ticks, 5);

      // Reset mid-count while q_a is 6, then while q_a is 9.
      guard = 0;
      while ((k_a % MA) != 6 && guard < 2 * MA) begin
         step(1'b0, 1'b0);
         guard++;
      end
      check("reach6_q_a", int'(q_a), 6);
      step(1'b1, 1'b0);
      check("mid_reset6_q_a", int'(q_a), 0);
      guard = 0;
      while ((k_a % MA) != 9 && guard < 2 * MA) begin
         step(1'b0, 1'b0);
         guard++;
      end
      check("reach9_tick_a", int'(tick_a), 1);
      step(1'b1, 1'b0);
      check("mid_reset9_q_a", int'(q_a), 0);
      check("mid_reset9_tick_a", int'(tick_a), 0);

      // Randomised resets on both instances.
      for (int i = 0; i < 400; i++) begin
         step(logic'($urandom_range(0, 15) == 0), logic'($urandom_range(0, 11) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mod_m_tick_counter.md
# mod_m_tick_counter

Free-running modulo-M counter that counts 0, 1, …, M-1 and then wraps to 0, indefinitely. It asserts a one-cycle terminal-count tick while the count equals M-1. It sits at the base of the timing chain (e.g. baud-rate / oversampling tick generator for the UART and morse timing logic), where `o_max_tick` serves as a periodic enable for downstream blocks. The RTL module name is `mod_m_tick_counter`.

## Interface

Parameters:
- `N`, default 4: width of the count register and `o_q`, in bits.
- `M`, default 10: modulus; the count sequence has period M clocks.
- Legal range: 2 ≤ M ≤ 2^N.

Ports:
- `i_clk`, input, 1 bit: clock; all state updates on the rising edge.
- `i_reset`, input, 1 bit: reset. One clock; reset is synchronous and active-high.
- `o_max_tick`, output, 1 bit: high while the count equals M-1.
- `o_q`, output, N bits: current count value, unsigned.

## Operation

- Single N-bit register `count`; `o_q` is driven directly from `count`.
- On each rising edge of `i_clk`:
  - `i_reset`=1: `count` ← 0.
  - Otherwise, if `count` = M-1: `count` ← 0.
  - Otherwise: `count` ← `count` + 1.
- `o_max_tick` = (`count` == M-1). It is combinational from the register, with no extra flop.
- No enable input: the counter advances every non-reset clock.
- Arithmetic is unsigned, N bits wide. The wrap is an explicit compare against M-1, not natural overflow. For M = 2^N the two coincide.
- `count` never holds a value ≥ M after reset.
- No state machine beyond the counter itself.

## Timing

- Reset values: `o_q` = 0, `o_max_tick` = 0 (for M ≥ 2), valid from the first rising edge sampled with `i_reset`=1.
- Reset mid-count: the next edge forces 0 regardless of the current value, including M-1. Reset takes precedence over the wrap.
- After reset deasserts, the k-th subsequent rising edge yields `o_q` = k mod M.
- `o_max_tick` is high for exactly one clock in every M. It is high during the cycle that follows the (M-1)-th edge after reset release, i.e. the cycle in which `o_q` = M-1.
- Tick-to-tick period: exactly M clocks.
- Outputs settle within one clock-to-q plus compare delay after the edge. Zero-cycle latency from `count` to `o_max_tick`.
- Downstream logic samples `o_max_tick` on the same `i_clk` edge that wraps the counter.

## Configuration

- Macro: `MOD_M_TICK_COUNTER_PARAM_CHECK_EN`.
- When defined:
  - An elaboration-time check reports a fatal error if M < 2 or M > 2^N.
  - A simulation check flags an error if `count` is ever ≥ M on a rising edge.
- When undefined: no checks are compiled. Functional behaviour is identical, and out-of-range parameters are the integrator's responsibility.

## Test plan

- Reset: assert `i_reset` for one edge -> `o_q`=0, `o_max_tick`=0.
- Count to max (N=4, M=10): release reset, apply 10 edges; sample each value before the next edge -> `o_q` steps 0..9; at `o_q`=9, `o_max_tick`=1.
- Wrap: 3 further edges -> `o_q` = 0, 1, 2; `o_max_tick`=0 at `o_q`=2; the tick fell the cycle `o_q` returned to 0.
- Periodicity: run 50 clocks -> `o_max_tick` high exactly 5 times, spaced 10 clocks apart, each for one clock.
- Reset mid-count: assert `i_reset` while `o_q`=6, and again while `o_q`=9 -> `o_q`=0 next edge; tick drops immediately.
- Power-of-two modulus (N=3, M=8): run 16 clocks -> `o_q` sequence 0..7, 0..7; tick at 7 only. With `MOD_M_TICK_COUNTER_PARAM_CHECK_EN` and M=9, N=3 -> elaboration error.
